// File: rtl/nam85_exec_core.sv
// nam85 execution core: halt clock gate, 8-bit ALU and T0..T4 microcoded control.
// Ports: clk/rst, ir_opcode, bus_in in; clk_out, A/flags, bus control word out.
module nam85_exec_core (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ir_opcode,
  input  logic [7:0] bus_in,
  output logic       clk_out,
  output logic [7:0] alu_out,
  output logic [7:0] alu_flags_out,
  output logic       alu_out_en,
  output logic       alu_flags_out_en,
  output logic       reg_out_en,
  output logic       reg_write_en,
  output logic [4:0] reg_read_sel,
  output logic [4:0] reg_write_sel,
  output logic [1:0] reg_ext_op,
  output logic       mem_out_en,
  output logic       mem_write_en,
  output logic       mem_mar_write_en,
  output logic       ir_write_en,
  output logic       output_alu,
  output logic       hlt
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } stage_t;

  localparam logic [4:0] SEL_PC = 5'd8;

  stage_t     stage;
  logic [7:0] a;
  logic [7:0] tmp;
  logic [7:0] act;
  logic [7:0] flags;
  logic       halted;

  assign clk_out       = clk & ~halted;
  assign alu_out       = a;
  assign alu_flags_out = flags;

  logic [2:0] d;
  logic [2:0] s;
  assign d = ir_opcode[5:3];
  assign s = ir_opcode[2:0];

  logic is_hlt, is_mov, is_mvi, is_alur, is_alui;
  logic is_inc, is_dec, is_ida, is_idr, is_cma, is_out;

  assign is_hlt  = ir_opcode == 8'h76;
  assign is_mov  = ir_opcode[7:6] == 2'b01 && d != 3'd6 && s != 3'd6;
  assign is_mvi  = ir_opcode[7:6] == 2'b00 && s == 3'd6 && d != 3'd6;
  assign is_alur = ir_opcode[7:6] == 2'b10 && s != 3'd6;
  assign is_alui = ir_opcode[7:6] == 2'b11 && s == 3'd6;
  assign is_inc  = ir_opcode[7:6] == 2'b00 && s == 3'd4 && d != 3'd6;
  assign is_dec  = ir_opcode[7:6] == 2'b00 && s == 3'd5 && d != 3'd6;
  assign is_ida  = (is_inc | is_dec) && d == 3'd7;
  assign is_idr  = (is_inc | is_dec) && d != 3'd7;
  assign is_cma  = ir_opcode == 8'h2F;
  assign is_out  = ir_opcode == 8'hD3;

  logic last;
  always_comb begin
    last = 1'b0;
    case (stage)
      T2:      last = !(is_mvi | is_alur | is_alui | is_idr);
      T3:      last = is_mvi | is_alur;
      T4:      last = 1'b1;
      default: last = 1'b0;
    endcase
  end

  // INR/DCR: carry is kept, AC is the nibble carry/borrow
  logic [7:0] id_res;
  logic       id_ac;
  logic [7:0] id_flags;
  always_comb begin
    id_res   = is_dec ? a - 8'd1 : a + 8'd1;
    id_ac    = is_dec ? (a[3:0] == 4'h0) : (a[3:0] == 4'hF);
    id_flags = {id_res[7], id_res == 8'd0, 1'b0, id_ac,
                1'b0, ~^id_res, 1'b0, flags[0]};
  end

  logic [8:0] sum;
  logic [4:0] nib;
  logic [7:0] alu_res;
  logic [7:0] alu_flags;
  logic       cin;
  logic       ncy;
  logic       nac;
  always_comb begin
    sum     = 9'd0;
    nib     = 5'd0;
    alu_res = 8'd0;
    ncy     = 1'b0;
    nac     = 1'b0;
    cin     = flags[0] & (d == 3'd1 || d == 3'd3);
    unique case (d)
      3'd0, 3'd1: begin
        sum     = {1'b0, a} + {1'b0, tmp} + {8'd0, cin};
        nib     = {1'b0, a[3:0]} + {1'b0, tmp[3:0]} + {4'd0, cin};
        alu_res = sum[7:0];
        ncy     = sum[8];
        nac     = nib[4];
      end
      3'd2, 3'd3, 3'd7: begin
        // bit 8 / bit 4 of the wrapped difference is the borrow
        sum     = {1'b0, a} - {1'b0, tmp} - {8'd0, cin};
        nib     = {1'b0, a[3:0]} - {1'b0, tmp[3:0]} - {4'd0, cin};
        alu_res = sum[7:0];
        ncy     = sum[8];
        nac     = nib[4];
      end
      3'd4: begin
        alu_res = a & tmp;
        nac     = 1'b1;
      end
      3'd5: alu_res = a ^ tmp;
      3'd6: alu_res = a | tmp;
    endcase
    alu_flags = {alu_res[7], alu_res == 8'd0, 1'b0, nac,
                 1'b0, ~^alu_res, 1'b0, ncy};
  end

  always_comb begin
    alu_out_en       = 1'b0;
    alu_flags_out_en = 1'b0;
    reg_out_en       = 1'b0;
    reg_write_en     = 1'b0;
    reg_read_sel     = 5'd0;
    reg_write_sel    = 5'd0;
    reg_ext_op       = 2'b00;
    mem_out_en       = 1'b0;
    mem_write_en     = 1'b0;
    mem_mar_write_en = 1'b0;
    ir_write_en      = 1'b0;
    output_alu       = 1'b0;
    hlt              = 1'b0;
    case (stage)
      T0: begin
        reg_read_sel     = SEL_PC;
        reg_out_en       = 1'b1;
        mem_mar_write_en = 1'b1;
      end
      T1: begin
        mem_out_en    = 1'b1;
        ir_write_en   = 1'b1;
        reg_write_sel = SEL_PC;
        reg_ext_op    = 2'b01;
      end
      T2: begin
        unique case (1'b1)
          is_mov, is_alur: begin
            if (s == 3'd7) begin
              alu_out_en = 1'b1;
            end else begin
              reg_read_sel = {2'b00, s};
              reg_out_en   = 1'b1;
            end
            if (is_mov && d != 3'd7) begin
              reg_write_sel = {2'b00, d};
              reg_write_en  = 1'b1;
            end
          end
          is_hlt: hlt = 1'b1;
          is_mvi, is_alui: begin
            reg_read_sel     = SEL_PC;
            reg_out_en       = 1'b1;
            mem_mar_write_en = 1'b1;
          end
          is_idr: begin
            reg_read_sel = {2'b00, d};
            reg_out_en   = 1'b1;
          end
          is_out: begin
            output_alu    = 1'b1;
            reg_write_sel = SEL_PC;
            reg_ext_op    = 2'b01;
          end
          default: ;
        endcase
      end
      T3: begin
        unique case (1'b1)
          is_mvi: begin
            mem_out_en = 1'b1;
            reg_ext_op = 2'b01;
            // the data write and the PC step share this step
            if (d != 3'd7) begin
              reg_write_sel = {2'b00, d};
              reg_write_en  = 1'b1;
            end else begin
              reg_write_sel = SEL_PC;
            end
          end
          is_alui: begin
            mem_out_en    = 1'b1;
            reg_write_sel = SEL_PC;
            reg_ext_op    = 2'b01;
          end
          default: ;
        endcase
      end
      T4: begin
        if (is_idr) begin
          alu_out_en    = 1'b1;
          reg_write_sel = {2'b00, d};
          reg_write_en  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stage  <= T0;
      a      <= 8'd0;
      tmp    <= 8'd0;
      act    <= 8'd0;
      flags  <= 8'd0;
      halted <= 1'b0;
    end else if (!halted) begin
      stage <= last ? T0 : stage_t'(stage + 3'd1);
      case (stage)
        T2: begin
          if (is_hlt) halted <= 1'b1;
          if (is_mov && d == 3'd7) a <= bus_in;
          if (is_alur) tmp <= bus_in;
          if (is_ida) begin
            a     <= id_res;
            flags <= id_flags;
          end
          if (is_idr) begin
            act <= a;
            a   <= bus_in;
          end
          if (is_cma) a <= ~a;
        end
        T3: begin
          if (is_mvi && d == 3'd7) a <= bus_in;
          if (is_alur) begin
            if (d != 3'd7) a <= alu_res;
            flags <= alu_flags;
          end
          if (is_alui) tmp <= bus_in;
          if (is_idr) begin
            a     <= id_res;
            flags <= id_flags;
          end
        end
        T4: begin
          if (is_alui) begin
            if (d != 3'd7) a <= alu_res;
            flags <= alu_flags;
          end
          // bus carries the stepped value this cycle; A is restored
          if (is_idr) a <= act;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nam85_exec_core.sv
// Directed bench for nam85_exec_core with a small bus/register model.
// Expected A/flags go through a scoreboard queue per instruction.
module tb_nam85_exec_core;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ir_opcode;
  logic [7:0] bus_in;
  logic       clk_out;
  logic [7:0] alu_out;
  logic [7:0] alu_flags_out;
  logic       alu_out_en;
  logic       alu_flags_out_en;
  logic       reg_out_en;
  logic       reg_write_en;
  logic [4:0] reg_read_sel;
  logic [4:0] reg_write_sel;
  logic [1:0] reg_ext_op;
  logic       mem_out_en;
  logic       mem_write_en;
  logic       mem_mar_write_en;
  logic       ir_write_en;
  logic       output_alu;
  logic       hlt;

  nam85_exec_core dut (
    .clk              (clk),
    .rst              (rst),
    .ir_opcode        (ir_opcode),
    .bus_in           (bus_in),
    .clk_out          (clk_out),
    .alu_out          (alu_out),
    .alu_flags_out    (alu_flags_out),
    .alu_out_en       (alu_out_en),
    .alu_flags_out_en (alu_flags_out_en),
    .reg_out_en       (reg_out_en),
    .reg_write_en     (reg_write_en),
    .reg_read_sel     (reg_read_sel),
    .reg_write_sel    (reg_write_sel),
    .reg_ext_op       (reg_ext_op),
    .mem_out_en       (mem_out_en),
    .mem_write_en     (mem_write_en),
    .mem_mar_write_en (mem_mar_write_en),
    .ir_write_en      (ir_write_en),
    .output_alu       (output_alu),
    .hlt              (hlt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] f;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] regs [0:15];
  logic [7:0] imm;
  logic [7:0] cur_op;
  logic [4:0] wr_sel;
  logic [7:0] wr_val;
  logic       out_seen;
  logic [7:0] out_val;
  logic       hlt_seen;
  logic       clk_hi;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock: drive opcode, model the bus, note writes/strobes
  task automatic tick();
    ir_opcode = cur_op;
    #1;
    bus_in = mem_out_en ? imm :
             reg_out_en ? regs[reg_read_sel[3:0]] :
             alu_out_en ? alu_out : 8'h00;
    if (reg_write_en === 1'b1) begin
      wr_sel = reg_write_sel;
      wr_val = bus_in;
      if (reg_write_sel < 5'd16) regs[reg_write_sel[3:0]] = bus_in;
    end
    if (output_alu === 1'b1) begin
      out_seen = 1'b1;
      out_val  = alu_out;
    end
    if (hlt === 1'b1) hlt_seen = 1'b1;
    @(posedge clk);
    #1;
    clk_hi = clk_out;
    @(negedge clk);
  endtask

  // starts in T1 of the fetch, ends in T1 of the next fetch
  task automatic exec(input string tag, input logic [7:0] op,
                      input logic [7:0] im, input logic [7:0] ea,
                      input logic [7:0] ef, input int cyc);
    exp_t e;
    sb.push_back('{a: ea, f: ef});
    cur_op   = op;
    imm      = im;
    out_seen = 1'b0;
    wr_sel   = 5'h1F;
    wr_val   = 8'h00;
    repeat (cyc - 1) tick();
    e = sb.pop_front();
    check({tag, ".a"}, alu_out, e.a);
    check({tag, ".f"}, alu_flags_out, e.f);
    check({tag, ".t0"}, 8'(mem_mar_write_en), 8'd1);
    tick();
    check({tag, ".cyc"}, 8'(ir_write_en), 8'd1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;
    cur_op   = 8'h00;
    imm      = 8'h00;
    bus_in   = 8'h00;
    hlt_seen = 1'b0;
    rst      = 1'b0;
    tick();
    rst = 1'b1;
    check("rst.a", alu_out, 8'h00);
    check("rst.f", alu_flags_out, 8'h00);
    check("rst.mar", 8'(mem_mar_write_en), 8'd1);
    check("rst.rsel", 8'(reg_read_sel), 8'd8);
    check("rst.hlt", 8'(hlt), 8'd0);
    tick();
    check("t1.irw", 8'(ir_write_en), 8'd1);
    check("t1.ext", 8'(reg_ext_op), 8'd1);
    check("clk_run", 8'(clk_hi), 8'd1);

    exec("mvi7f", 8'h3E, 8'h7F, 8'h7F, 8'h00, 4);
    exec("adi01", 8'hC6, 8'h01, 8'h80, 8'h90, 5);
    exec("mvi05", 8'h3E, 8'h05, 8'h05, 8'h90, 4);
    exec("sui06", 8'hD6, 8'h06, 8'hFF, 8'h95, 5);
    exec("mvi42", 8'h3E, 8'h42, 8'h42, 8'h95, 4);
    regs[0] = 8'h42;
    exec("cmpb", 8'hB8, 8'h00, 8'h42, 8'h44, 4);
    exec("mvi00", 8'h3E, 8'h00, 8'h00, 8'h44, 4);
    exec("sui01", 8'hD6, 8'h01, 8'hFF, 8'h95, 5);
    exec("mvi10", 8'h3E, 8'h10, 8'h10, 8'h95, 4);
    regs[0] = 8'hFF;
    exec("inrb", 8'h04, 8'h00, 8'h10, 8'h55, 5);
    check("inrb.wsel", 8'(wr_sel), 8'd0);
    check("inrb.wval", wr_val, 8'h00);
    exec("movca", 8'h4F, 8'h00, 8'h10, 8'h55, 3);
    check("movca.wsel", 8'(wr_sel), 8'd1);
    check("movca.wval", wr_val, 8'h10);
    regs[2] = 8'h3C;
    exec("movad", 8'h7A, 8'h00, 8'h3C, 8'h55, 3);
    exec("cma", 8'h2F, 8'h00, 8'hC3, 8'h55, 3);
    exec("dcra", 8'h3D, 8'h00, 8'hC2, 8'h81, 3);
    exec("xraa", 8'hAF, 8'h00, 8'h00, 8'h44, 4);
    exec("adi3a", 8'hC6, 8'h3A, 8'h3A, 8'h04, 5);
    exec("ani0f", 8'hE6, 8'h0F, 8'h0A, 8'h14, 5);
    exec("adif8", 8'hC6, 8'hF8, 8'h02, 8'h11, 5);
    exec("aci00", 8'hCE, 8'h00, 8'h03, 8'h04, 5);
    exec("out", 8'hD3, 8'h00, 8'h03, 8'h04, 3);
    check("out.strobe", 8'(out_seen), 8'd1);
    check("out.val", out_val, 8'h03);
    regs[3] = 8'h00;
    exec("dcre", 8'h1D, 8'h00, 8'h03, 8'h94, 5);
    check("dcre.wsel", 8'(wr_sel), 8'd3);
    check("dcre.wval", wr_val, 8'hFF);

    cur_op = 8'h76;
    tick();
    check("hlt.t2", 8'(hlt), 8'd1);
    check("clk_pre", 8'(clk_hi), 8'd1);
    tick();
    check("hlt.seen", 8'(hlt_seen), 8'd1);
    check("hlt.gate", 8'(clk_hi), 8'd0);
    cur_op = 8'h3E;
    imm    = 8'hAA;
    repeat (4) tick();
    check("frz.a", alu_out, 8'h03);
    check("frz.f", alu_flags_out, 8'h94);
    check("frz.t0", 8'(mem_mar_write_en), 8'd1);
    check("frz.irw", 8'(ir_write_en), 8'd0);
    check("frz.gate", 8'(clk_hi), 8'd0);

    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst2.a", alu_out, 8'h00);
    check("rst2.f", alu_flags_out, 8'h00);
    check("rst2.gate", 8'(clk_hi), 8'd1);
    check("rst2.t0", 8'(mem_mar_write_en), 8'd1);
    tick();
    check("rst2.t1", 8'(ir_write_en), 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
